ss_key_ctrl: RTL

- Consumes the decoded system configuration: save/load/menu key codes, the in-game-menu enable and the external-button select.
- Watches the joypad byte sniffed once per frame and the cartridge's external button.
- Issues one save-state request at a time (save, load or menu) to the save-state/menu engine, using a req/ack handshake.
- Sits between the config register block and the save-state engine inside the mapper base library.

---
 rtl/ss_key_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/ss_key_ctrl.sv
// Save-state key controller: turns pad key combos and a debounced external button
// into one-at-a-time save/load/menu requests with a req/ack handshake.
module ss_key_ctrl #(
  parameter int unsigned HOLD_FRAMES = 4,
  parameter int unsigned REL_FRAMES  = 2,
  parameter int unsigned DEB_CYC     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ss_on,
  input  logic       ss_btn,
  input  logic [7:0] key_save,
  input  logic [7:0] key_load,
  input  logic [7:0] key_menu,
  input  logic [7:0] pad_dat,
  input  logic       pad_vld,
  input  logic       ext_btn,
  input  logic       ack,
  output logic       req_save,
  output logic       req_load,
  output logic       req_menu,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StArm, StReq, StWaitRel} state_e;

  localparam logic [1:0]  TgtNone  = 2'd0;
  localparam logic [1:0]  TgtSave  = 2'd1;
  localparam logic [1:0]  TgtLoad  = 2'd2;
  localparam logic [1:0]  TgtMenu  = 2'd3;
  localparam logic [3:0]  HoldLast = 4'(HOLD_FRAMES);
  localparam logic [3:0]  RelLast  = 4'(REL_FRAMES);
  localparam logic [15:0] DebLast  = 16'(DEB_CYC - 1);

  state_e      state;
  logic [1:0]  target;
  logic [3:0]  cnt;
  logic [3:0]  rcnt;
  logic [2:0]  req;    // {menu, load, save}

  logic        btn_s1;
  logic        btn_s2;
  logic        btn_deb;
  logic [15:0] deb_cnt;
  logic        btn_rise;

  logic        m_save;
  logic        m_load;
  logic        m_menu;
  logic [1:0]  sel;

  function automatic logic [2:0] req_of(input logic [1:0] t);
    case (t)
      TgtSave: req_of = 3'b001;
      TgtLoad: req_of = 3'b010;
      TgtMenu: req_of = 3'b100;
      default: req_of = 3'b000;
    endcase
  endfunction

  // Synchroniser and debouncer run regardless of ss_on so a held button never fires late.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1  <= 1'b0;
      btn_s2  <= 1'b0;
      btn_deb <= 1'b0;
      deb_cnt <= 16'd0;
    end else begin
      btn_s1 <= ext_btn;
      btn_s2 <= btn_s1;
      if (btn_s2 == btn_deb) begin
        deb_cnt <= 16'd0;
      end else if (deb_cnt == DebLast) begin
        btn_deb <= btn_s2;
        deb_cnt <= 16'd0;
      end else begin
        deb_cnt <= deb_cnt + 16'd1;
      end
    end
  end

  assign btn_rise = btn_s2 && !btn_deb && (deb_cnt == DebLast);

  always_comb begin
    m_save = (key_save != 8'd0) && (pad_dat == key_save);
    m_load = (key_load != 8'd0) && (pad_dat == key_load);
    m_menu = (key_menu != 8'd0) && (pad_dat == key_menu);
    sel    = TgtNone;
    if (m_menu)      sel = TgtMenu;
    else if (m_save) sel = TgtSave;
    else if (m_load) sel = TgtLoad;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= StIdle;
      target <= TgtNone;
      cnt    <= 4'd0;
      rcnt   <= 4'd0;
      req    <= 3'b000;
    end else if (!ss_on) begin
      state <= StIdle;
      cnt   <= 4'd0;
      rcnt  <= 4'd0;
      req   <= 3'b000;
    end else if (btn_rise && ss_btn && (state == StIdle || state == StArm)) begin
      target <= TgtMenu;
      state  <= StReq;
      cnt    <= 4'd0;
      req    <= 3'b100;
    end else begin
      case (state)
        StIdle, StArm: begin
          if (pad_vld) begin
            if (sel == TgtNone) begin
              state <= StIdle;
              cnt   <= 4'd0;
            end else if (state == StArm && sel == target) begin
              if (cnt + 4'd1 == HoldLast) begin
                state <= StReq;
                cnt   <= 4'd0;
                req   <= req_of(target);
              end else begin
                cnt <= cnt + 4'd1;
              end
            end else begin
              // Fresh match from IDLE, or a different key taking over an ARM in progress.
              target <= sel;
              if (HoldLast == 4'd1) begin
                state <= StReq;
                cnt   <= 4'd0;
                req   <= req_of(sel);
              end else begin
                state <= StArm;
                cnt   <= 4'd1;
              end
            end
          end
        end
        StReq: begin
          if (ack) begin
            state <= StWaitRel;
            rcnt  <= 4'd0;
            req   <= 3'b000;
          end
        end
        StWaitRel: begin
          if (pad_vld) begin
            if (pad_dat != 8'd0) begin
              rcnt <= 4'd0;
            end else if (rcnt + 4'd1 == RelLast) begin
              state <= StIdle;
              rcnt  <= 4'd0;
            end else begin
              rcnt <= rcnt + 4'd1;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign req_save = req[0];
  assign req_load = req[1];
  assign req_menu = req[2];
  assign busy     = (state != StIdle);

endmodule
